// File: rtl/blink_seq_pkg.sv
// Shared types and constants for the blink pattern sequencer.
//   state_e    : sequencer FSM states
//   FLD_*      : cfg_field codes selecting a scene word
//   dwell_min1 : treats a zero dwell as one millisecond
package blink_seq_pkg;

    localparam int unsigned PERIOD_W = 16;
    localparam int unsigned DWELL_W  = 16;
    localparam int unsigned FIELD_W  = 3;
    localparam int unsigned NUM_CH   = 4;

    localparam logic [FIELD_W-1:0] FLD_P0    = 3'd0;
    localparam logic [FIELD_W-1:0] FLD_P1    = 3'd1;
    localparam logic [FIELD_W-1:0] FLD_P2    = 3'd2;
    localparam logic [FIELD_W-1:0] FLD_P3    = 3'd3;
    localparam logic [FIELD_W-1:0] FLD_DWELL = 3'd4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2
    } state_e;

    function automatic logic [DWELL_W-1:0] dwell_min1(input logic [DWELL_W-1:0] d);
        return (d == '0) ? DWELL_W'(1) : d;
    endfunction

endpackage

// File: rtl/ms_tick_gen.sv
// Millisecond prescaler: counts enabled cycles 0..CLK_PER_MS-1 and pulses
// tick during the last count of each period.
//   clk, reset : clock, async active-low reset
//   clr        : force the count back to 0 (wins over en)
//   en         : advance the count; 0 freezes it
//   tick       : one-cycle pulse, combinational from the count and en
module ms_tick_gen #(
    parameter int unsigned CLK_PER_MS = 100000
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic tick
);

    localparam int unsigned CNT_W = $clog2(CLK_PER_MS);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign tick = en && (cnt_q == CNT_W'(CLK_PER_MS - 1));

    // Next count: clear, wrap on tick, or advance when enabled
    always_comb begin
        cnt_d = cnt_q;
        if (clr || tick) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/blink_pattern_sequencer.sv
// Steps through a programmable table of LED scenes (four period words plus
// a dwell in ms) and drives the blinker period registers.
//   cfg_we/cfg_addr/cfg_field/cfg_wdata : scene table write port
//   last_idx, loop_en                   : sequence end and wrap control
//   start, stop (pulses), pause (level) : run control
//   reg_out0..3                         : registered period words
//   cur_idx                             : scene currently driven
//   busy                                : RUN or PAUSE (from state register)
//   done                                : one-cycle pulse at one-shot end
module blink_pattern_sequencer
    import blink_seq_pkg::*;
#(
    parameter int unsigned DEPTH      = 8,
    parameter int unsigned ADDR_W     = $clog2(DEPTH),
    parameter int unsigned CLK_PER_MS = 100000
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                cfg_we,
    input  logic [ADDR_W-1:0]   cfg_addr,
    input  logic [FIELD_W-1:0]  cfg_field,
    input  logic [15:0]         cfg_wdata,
    input  logic [ADDR_W-1:0]   last_idx,
    input  logic                loop_en,
    input  logic                start,
    input  logic                stop,
    input  logic                pause,
    output logic [PERIOD_W-1:0] reg_out0,
    output logic [PERIOD_W-1:0] reg_out1,
    output logic [PERIOD_W-1:0] reg_out2,
    output logic [PERIOD_W-1:0] reg_out3,
    output logic [ADDR_W-1:0]   cur_idx,
    output logic                busy,
    output logic                done
);

    logic [PERIOD_W-1:0] period_q [DEPTH][NUM_CH];
    logic [DWELL_W-1:0]  dwell_q  [DEPTH];

    state_e              state_q, state_d;
    logic [PERIOD_W-1:0] reg_out_q [NUM_CH];
    logic [PERIOD_W-1:0] reg_out_d [NUM_CH];
    logic [ADDR_W-1:0]   cur_idx_q, cur_idx_d;
    logic [DWELL_W-1:0]  dwell_cnt_q, dwell_cnt_d;
    logic                done_q, done_d;

    logic                ms_tick;
    logic                tick_en;
    logic                tick_clr;
    logic                expiry;
    logic                load;
    logic [ADDR_W-1:0]   load_idx;

    // Counters advance only while running and not being paused or stopped,
    // so a pause freezes exactly the cycles in which pause is high.
    assign tick_en  = (state_q != IDLE) && !stop && !pause;
    assign expiry   = ms_tick && (dwell_cnt_q == DWELL_W'(1));
    assign tick_clr = (state_q == IDLE) || expiry;

    ms_tick_gen #(
        .CLK_PER_MS (CLK_PER_MS)
    ) u_ms_tick (
        .clk   (clk),
        .reset (reset),
        .clr   (tick_clr),
        .en    (tick_en),
        .tick  (ms_tick)
    );

    // Scene table; contents are deliberately not reset
    always_ff @(posedge clk) begin
        if (cfg_we) begin
            case (cfg_field)
                FLD_P0:    period_q[cfg_addr][0] <= cfg_wdata;
                FLD_P1:    period_q[cfg_addr][1] <= cfg_wdata;
                FLD_P2:    period_q[cfg_addr][2] <= cfg_wdata;
                FLD_P3:    period_q[cfg_addr][3] <= cfg_wdata;
                FLD_DWELL: dwell_q[cfg_addr]     <= cfg_wdata;
                default:   ;
            endcase
        end
    end

    // Next-state and scene-load logic
    always_comb begin
        state_d     = state_q;
        cur_idx_d   = cur_idx_q;
        dwell_cnt_d = dwell_cnt_q;
        done_d      = 1'b0;
        load        = 1'b0;
        load_idx    = '0;
        for (int ch = 0; ch < int'(NUM_CH); ch++) begin
            reg_out_d[ch] = reg_out_q[ch];
        end

        unique case (state_q)
            IDLE: begin
                if (start && !stop) begin
                    state_d = RUN;
                    load    = 1'b1;
                end
            end
            RUN, PAUSE: begin
                if (stop) begin
                    state_d = IDLE;
                end else begin
                    state_d = pause ? PAUSE : RUN;
                    if (expiry) begin
                        // last_idx below cur_idx also ends the sequence
                        if (cur_idx_q < last_idx) begin
                            load     = 1'b1;
                            load_idx = cur_idx_q + ADDR_W'(1);
                        end else if (loop_en) begin
                            load = 1'b1;
                        end else begin
                            state_d = IDLE;
                            done_d  = 1'b1;
                        end
                    end else if (ms_tick) begin
                        dwell_cnt_d = dwell_cnt_q - DWELL_W'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (load) begin
            cur_idx_d   = load_idx;
            dwell_cnt_d = dwell_min1(dwell_q[load_idx]);
            for (int ch = 0; ch < int'(NUM_CH); ch++) begin
                reg_out_d[ch] = period_q[load_idx][ch];
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            cur_idx_q   <= '0;
            dwell_cnt_q <= '0;
            done_q      <= 1'b0;
            for (int ch = 0; ch < int'(NUM_CH); ch++) begin
                reg_out_q[ch] <= '0;
            end
        end else begin
            state_q     <= state_d;
            cur_idx_q   <= cur_idx_d;
            dwell_cnt_q <= dwell_cnt_d;
            done_q      <= done_d;
            for (int ch = 0; ch < int'(NUM_CH); ch++) begin
                reg_out_q[ch] <= reg_out_d[ch];
            end
        end
    end

    assign reg_out0 = reg_out_q[0];
    assign reg_out1 = reg_out_q[1];
    assign reg_out2 = reg_out_q[2];
    assign reg_out3 = reg_out_q[3];
    assign cur_idx  = cur_idx_q;
    assign done     = done_q;
    assign busy     = (state_q == RUN) || (state_q == PAUSE);

endmodule

// File: tb/tb_blink_pattern_sequencer.sv
// Directed bench for blink_pattern_sequencer with CLK_PER_MS=4, DEPTH=8.
// Inputs change 1 time unit after the rising edge; outputs are checked there.
module tb_blink_pattern_sequencer;

    localparam int unsigned DEPTH  = 8;
    localparam int unsigned ADDR_W = 3;

    logic              clk;
    logic              reset;
    logic              cfg_we;
    logic [ADDR_W-1:0] cfg_addr;
    logic [2:0]        cfg_field;
    logic [15:0]       cfg_wdata;
    logic [ADDR_W-1:0] last_idx;
    logic              loop_en;
    logic              start;
    logic              stop;
    logic              pause;
    logic [15:0]       reg_out0, reg_out1, reg_out2, reg_out3;
    logic [ADDR_W-1:0] cur_idx;
    logic              busy;
    logic              done;

    int checks = 0;
    int passed = 0;
    int fails  = 0;
    logic done_seen;

    blink_pattern_sequencer #(
        .DEPTH      (DEPTH),
        .ADDR_W     (ADDR_W),
        .CLK_PER_MS (4)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .cfg_we    (cfg_we),
        .cfg_addr  (cfg_addr),
        .cfg_field (cfg_field),
        .cfg_wdata (cfg_wdata),
        .last_idx  (last_idx),
        .loop_en   (loop_en),
        .start     (start),
        .stop      (stop),
        .pause     (pause),
        .reg_out0  (reg_out0),
        .reg_out1  (reg_out1),
        .reg_out2  (reg_out2),
        .reg_out3  (reg_out3),
        .cur_idx   (cur_idx),
        .busy      (busy),
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_scene(input string tag, input logic [15:0] e0, input logic [15:0] e1,
                               input logic [15:0] e2, input logic [15:0] e3);
        check({tag, ".reg_out0"}, 32'(reg_out0), 32'(e0));
        check({tag, ".reg_out1"}, 32'(reg_out1), 32'(e1));
        check({tag, ".reg_out2"}, 32'(reg_out2), 32'(e2));
        check({tag, ".reg_out3"}, 32'(reg_out3), 32'(e3));
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wr(input logic [ADDR_W-1:0] a, input logic [2:0] f, input logic [15:0] d);
        cfg_we    = 1'b1;
        cfg_addr  = a;
        cfg_field = f;
        cfg_wdata = d;
        step(1);
        cfg_we    = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step(1);
        start = 1'b0;
    endtask

    task automatic pulse_stop();
        stop = 1'b1;
        step(1);
        stop = 1'b0;
    endtask

    initial begin
        reset     = 1'b0;
        cfg_we    = 1'b0;
        cfg_addr  = '0;
        cfg_field = '0;
        cfg_wdata = '0;
        last_idx  = 3'd1;
        loop_en   = 1'b0;
        start     = 1'b0;
        stop      = 1'b0;
        pause     = 1'b0;

        // Reset state
        step(3);
        check_scene("rst", 16'd0, 16'd0, 16'd0, 16'd0);
        check("rst.cur_idx", 32'(cur_idx), 32'd0);
        check("rst.busy", 32'(busy), 32'd0);
        check("rst.done", 32'(done), 32'd0);
        reset = 1'b1;
        step(1);

        // Program scenes 0 and 1
        wr(3'd0, 3'd0, 16'd100);
        wr(3'd0, 3'd1, 16'd200);
        wr(3'd0, 3'd2, 16'd300);
        wr(3'd0, 3'd3, 16'd400);
        wr(3'd0, 3'd4, 16'd2);
        wr(3'd1, 3'd0, 16'd5);
        wr(3'd1, 3'd1, 16'd6);
        wr(3'd1, 3'd2, 16'd7);
        wr(3'd1, 3'd3, 16'd8);
        wr(3'd1, 3'd4, 16'd3);

        // Idle with start low
        step(100);
        check("idle.reg_out0", 32'(reg_out0), 32'd0);
        check("idle.busy", 32'(busy), 32'd0);

        // One-shot: scene 0 for 8 cycles, scene 1 for 12, then done
        pulse_start();
        check_scene("os.s0", 16'd100, 16'd200, 16'd300, 16'd400);
        check("os.s0.busy", 32'(busy), 32'd1);
        step(7);
        check("os.s0_end.cur_idx", 32'(cur_idx), 32'd0);
        check("os.s0_end.reg_out3", 32'(reg_out3), 32'd400);
        step(1);
        check_scene("os.s1", 16'd5, 16'd6, 16'd7, 16'd8);
        check("os.s1.cur_idx", 32'(cur_idx), 32'd1);
        step(11);
        check("os.s1_end.busy", 32'(busy), 32'd1);
        check("os.s1_end.done", 32'(done), 32'd0);
        step(1);
        check("os.fin.done", 32'(done), 32'd1);
        check("os.fin.busy", 32'(busy), 32'd0);
        check("os.fin.cur_idx", 32'(cur_idx), 32'd1);
        check_scene("os.fin", 16'd5, 16'd6, 16'd7, 16'd8);
        step(1);
        check("os.post.done", 32'(done), 32'd0);

        // Loop: 0,1,0,1 with 20-cycle period, no done
        loop_en   = 1'b1;
        done_seen = 1'b0;
        pulse_start();
        check("loop.a.cur_idx", 32'(cur_idx), 32'd0);
        for (int i = 0; i < 8; i++) begin step(1); done_seen |= done; end
        check("loop.b.cur_idx", 32'(cur_idx), 32'd1);
        for (int i = 0; i < 12; i++) begin step(1); done_seen |= done; end
        check("loop.c.cur_idx", 32'(cur_idx), 32'd0);
        check("loop.c.reg_out0", 32'(reg_out0), 32'd100);
        for (int i = 0; i < 8; i++) begin step(1); done_seen |= done; end
        check("loop.d.cur_idx", 32'(cur_idx), 32'd1);
        check("loop.no_done", 32'(done_seen), 32'd0);
        pulse_stop();
        check("loop.stop.busy", 32'(busy), 32'd0);
        check("loop.stop.cur_idx", 32'(cur_idx), 32'd1);
        check("loop.stop.reg_out0", 32'(reg_out0), 32'd5);
        step(10);
        check("loop.hold.reg_out0", 32'(reg_out0), 32'd5);
        check("loop.hold.done", 32'(done), 32'd0);
        loop_en = 1'b0;

        // Pause 10 cycles starting 3 cycles into scene 0: hold becomes 18
        pulse_start();
        step(3);
        pause = 1'b1;
        step(10);
        check("pause.busy", 32'(busy), 32'd1);
        check("pause.reg_out0", 32'(reg_out0), 32'd100);
        check("pause.cur_idx", 32'(cur_idx), 32'd0);
        pause = 1'b0;
        step(4);
        check("pause.s0_end.cur_idx", 32'(cur_idx), 32'd0);
        step(1);
        check("pause.s1.cur_idx", 32'(cur_idx), 32'd1);
        check("pause.s1.reg_out0", 32'(reg_out0), 32'd5);
        pulse_stop();

        // Zero dwell behaves as 1 ms (4 cycles)
        wr(3'd0, 3'd4, 16'd0);
        last_idx = 3'd0;
        pulse_start();
        step(3);
        check("dw0.busy", 32'(busy), 32'd1);
        check("dw0.done_early", 32'(done), 32'd0);
        step(1);
        check("dw0.done", 32'(done), 32'd1);
        check("dw0.idle", 32'(busy), 32'd0);
        wr(3'd0, 3'd4, 16'd2);
        last_idx = 3'd1;

        // start and stop together from IDLE
        start = 1'b1;
        stop  = 1'b1;
        step(1);
        start = 1'b0;
        stop  = 1'b0;
        check("ss.busy", 32'(busy), 32'd0);

        // start during RUN is ignored
        pulse_start();
        step(5);
        pulse_start();
        check("rerun.cur_idx", 32'(cur_idx), 32'd0);
        check("rerun.busy", 32'(busy), 32'd1);
        step(2);
        check("rerun.no_restart", 32'(cur_idx), 32'd1);
        pulse_stop();

        // Live writes: future scene takes effect, active scene does not change
        pulse_start();
        step(2);
        wr(3'd1, 3'd0, 16'd999);
        step(5);
        check("live.cur_idx", 32'(cur_idx), 32'd1);
        check("live.reg_out0", 32'(reg_out0), 32'd999);
        wr(3'd1, 3'd1, 16'd777);
        check("live.active.reg_out1", 32'(reg_out1), 32'd6);
        step(11);
        check("live.done", 32'(done), 32'd1);
        check("live.fin.reg_out1", 32'(reg_out1), 32'd6);

        // Asynchronous reset mid-sequence
        loop_en = 1'b1;
        pulse_start();
        step(10);
        check("mid.cur_idx", 32'(cur_idx), 32'd1);
        #2 reset = 1'b0;
        #1;
        check_scene("mid.rst", 16'd0, 16'd0, 16'd0, 16'd0);
        check("mid.rst.busy", 32'(busy), 32'd0);
        check("mid.rst.cur_idx", 32'(cur_idx), 32'd0);
        #2 reset = 1'b1;
        loop_en = 1'b0;
        step(100);
        check("mid.idle.reg_out0", 32'(reg_out0), 32'd0);
        check("mid.idle.busy", 32'(busy), 32'd0);
        check("mid.idle.cur_idx", 32'(cur_idx), 32'd0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/blink_pattern_sequencer.md
Name: blink_pattern_sequencer

Overview:
Controller that sequences the four-channel blinking-LED datapath. It holds a small programmable table of "scenes"; each scene is four 16-bit blink-period words plus a dwell time in milliseconds. The block steps through the scenes in order and drives the four period registers (reg_out0..3) that feed the LED blinker instances. It sits between the CPU/register interface (cfg_* writes, start/stop/pause) and the blinker top.

Parameters:
DEPTH, 8, number of scene entries (power of two, 2..256)
ADDR_W, $clog2(DEPTH), scene index width
CLK_PER_MS, 100000, clk cycles per millisecond tick (>=2; set to 4 in simulation)

Ports:
clk  in  1  system clock; all logic on rising edge
reset  in  1  asynchronous, active-low reset (asserted when 0)
cfg_we  in  1  table write strobe, one write per cycle
cfg_addr  in  ADDR_W  scene index to write
cfg_field  in  3  0..3 = period word for channel 0..3; 4 = dwell_ms; 5..7 = ignored
cfg_wdata  in  16  write data
last_idx  in  ADDR_W  index of the final scene in the sequence
loop_en  in  1  1 = wrap to scene 0 after last_idx; 0 = one-shot
start  in  1  single-cycle start pulse
stop  in  1  single-cycle stop pulse
pause  in  1  level; freezes the sequence while 1
reg_out0..reg_out3  out  16 each  period words to blinker channels 0..3
cur_idx  out  ADDR_W  scene currently driven
busy  out  1  1 in RUN or PAUSE
done  out  1  one-cycle pulse when a one-shot sequence completes

Behaviour:
- Reset (reset==0, asynchronous): state=IDLE; reg_out0..3=0; cur_idx=0; busy=0; done=0; dwell counter and prescaler=0. Table contents are not reset (undefined until written).
- Table: DEPTH x 5 x 16 registers. A write lands on the clock edge and is readable the next cycle. Writes are permitted in every state. A write to the running scene does not alter reg_out until that scene is next loaded.
- FSM states: IDLE, RUN, PAUSE.
- IDLE, start=1 and stop=0: on that edge, load scene 0 into reg_out0..3, set cur_idx=0, dwell_cnt=max(dwell_ms[0],1), prescaler=0, and go to RUN. reg_out is valid 1 cycle after start.
- RUN: prescaler counts 0..CLK_PER_MS-1 and emits ms_tick on its wrap; each ms_tick decrements dwell_cnt.
  - Expiry is an ms_tick with dwell_cnt==1. Each scene is held exactly max(D,1)*CLK_PER_MS cycles.
  - On expiry with cur_idx!=last_idx: load scene cur_idx+1 on the same edge and reset the prescaler.
  - On expiry with cur_idx==last_idx and loop_en=1: load scene 0.
  - On expiry with cur_idx==last_idx and loop_en=0: go to IDLE, pulse done for 1 cycle, and hold reg_out and cur_idx at their last values.
- dwell_ms=0 is treated as 1 ms.
- last_idx is sampled at each expiry. If last_idx < cur_idx at expiry, treat it as the end of the sequence.
- RUN, pause=1: go to PAUSE. The prescaler and dwell_cnt freeze; outputs hold.
- PAUSE, pause=0: return to RUN and resume from the frozen counts with no lost cycles.
- stop=1 in RUN or PAUSE: go to IDLE next edge, no done pulse, reg_out and cur_idx hold.
- stop has priority over start, pause and expiry in the same cycle.
- start while busy is ignored. start while pause=1 in IDLE enters RUN, then PAUSE on the following cycle.
- Reset mid-sequence: everything returns to reset values immediately, regardless of clk.
- busy is asserted combinationally from the state register (1 in RUN or PAUSE). done is registered.

Decomposition:
- Shared package blink_seq_pkg:
  - state enum {IDLE, RUN, PAUSE}
  - field codes FLD_P0..FLD_P3=0..3 and FLD_DWELL=4
  - PERIOD_W=16, DWELL_W=16
- One sub-module, ms_tick_gen:
  - prescaler with parameter CLK_PER_MS
  - inputs clk, reset, clr, en
  - output tick (1-cycle pulse)
  - reused by the blinker channels if they are later refactored.

Test Plan:
- Reset and idle: hold reset=0 mid-run, then release -> reg_out0..3=0, busy=0, cur_idx=0; no change with start low for 100 cycles.
- One-shot: CLK_PER_MS=4, scenes 0/1 = {100,200,300,400,dwell 2} and {5,6,7,8,dwell 3}, last_idx=1, loop_en=0, pulse start -> scene 0 on reg_out 1 cycle later for 8 cycles, then scene 1 for 12 cycles, then done=1 for 1 cycle, busy=0, reg_out stays {5,6,7,8}.
- Loop: same table with loop_en=1 -> cur_idx sequence 0,1,0,1 with period 20 cycles; done never pulses; stop -> IDLE next edge, outputs hold.
- Pause: assert pause 3 cycles into scene 0 for 10 cycles -> reg_out frozen; scene 0 total hold = 8 + 10 cycles; busy stays 1.
- Edge cases:
  - dwell=0 -> 4-cycle hold.
  - start and stop in the same cycle from IDLE -> remains IDLE.
  - start during RUN -> ignored, no restart.
- Live write: write scene 1 ch0=999 while scene 0 is running -> reg_out0=999 when scene 1 loads.
- Live write to the active scene -> no change until that scene reloads.
